// File: rtl/board_pkg.sv
// Shared Minesweeper board definitions: tile codes, colour palette and the
// pixel/timing bundle handed between VGA pipeline stages.
package board_pkg;

    typedef enum logic [3:0] {
        T_REV0   = 4'd0,
        T_REV1   = 4'd1,
        T_REV2   = 4'd2,
        T_REV3   = 4'd3,
        T_REV4   = 4'd4,
        T_REV5   = 4'd5,
        T_REV6   = 4'd6,
        T_REV7   = 4'd7,
        T_REV8   = 4'd8,
        T_HIDDEN = 4'd9,
        T_FLAG   = 4'd10,
        T_MINE   = 4'd11
    } tile_code_t;

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam logic [11:0] GRID_RGB     = 12'h4_4_4;
    localparam logic [11:0] REVEALED_RGB = 12'hC_C_C;
    localparam logic [11:0] HIDDEN_RGB   = 12'hA_A_A;
    localparam logic [11:0] BEVEL_HI_RGB = 12'hE_E_E;
    localparam logic [11:0] BEVEL_LO_RGB = 12'h6_6_6;
    localparam logic [11:0] FLAG_RGB     = 12'hF_0_0;
    localparam logic [11:0] MINE_BG_RGB  = 12'hF_0_0;
    localparam logic [11:0] MINE_RGB     = 12'h0_0_0;
    localparam logic [11:0] CURSOR_RGB   = 12'hF_F_0;

    // Classic neighbour-count palette, indexed by the revealed count.
    localparam logic [11:0] COUNT_RGB [1:8] = '{
        12'h0_0_F, 12'h0_8_0, 12'hF_0_0, 12'h0_0_8,
        12'h8_0_0, 12'h0_8_8, 12'h0_0_0, 12'h8_8_8
    };

    function automatic logic [11:0] count_rgb(input logic [3:0] code);
        case (code)
            4'd1:    return COUNT_RGB[1];
            4'd2:    return COUNT_RGB[2];
            4'd3:    return COUNT_RGB[3];
            4'd4:    return COUNT_RGB[4];
            4'd5:    return COUNT_RGB[5];
            4'd6:    return COUNT_RGB[6];
            4'd7:    return COUNT_RGB[7];
            4'd8:    return COUNT_RGB[8];
            default: return REVEALED_RGB;
        endcase
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus pixel colour as passed between pipeline stages.
// Modport "in" is the consuming side, "out" the producing side.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/tile_painter.sv
// Combinational colour of one pixel inside a tile, from its code and offsets.
// Board-edge grid lines are the caller's job; tile-edge lines are drawn here.
module tile_painter
    import board_pkg::*;
#(
    parameter int TILE_LOG2 = 5
) (
    input  logic [3:0]           code,
    input  logic [TILE_LOG2-1:0] offx,
    input  logic [TILE_LOG2-1:0] offy,
    input  logic                 cursor_hit,
    output logic [11:0]          rgb
);

    localparam int          TILE   = 1 << TILE_LOG2;
    localparam logic [31:0] CTR_LO = 32'(TILE / 4);
    localparam logic [31:0] CTR_HI = 32'(TILE - TILE / 4);
    localparam logic [31:0] LO_EDG = 32'(TILE - 2);

    logic [31:0] ox;
    logic [31:0] oy;
    logic        centre;
    logic        bevel_hi;
    logic        bevel_lo;

    assign ox = 32'(offx);
    assign oy = 32'(offy);

    // |off - TILE/2| < TILE/4 is the open interval (TILE/4, 3*TILE/4).
    assign centre   = (ox > CTR_LO) && (ox < CTR_HI) && (oy > CTR_LO) && (oy < CTR_HI);
    assign bevel_hi = (ox >= 32'd1 && ox <= 32'd2) || (oy >= 32'd1 && oy <= 32'd2);
    assign bevel_lo = (ox >= LO_EDG) || (oy >= LO_EDG);

    always_comb begin
        rgb = HIDDEN_RGB;
        if (offx == '0 || offy == '0) begin
            rgb = GRID_RGB;
        end else if (cursor_hit && (bevel_hi || bevel_lo)) begin
            rgb = CURSOR_RGB;
        end else if (code <= T_REV8) begin
            rgb = (code != T_REV0 && centre) ? count_rgb(code) : REVEALED_RGB;
        end else if (code == T_MINE) begin
            rgb = centre ? MINE_RGB : MINE_BG_RGB;
        end else if (bevel_hi) begin
            rgb = BEVEL_HI_RGB;
        end else if (bevel_lo) begin
            rgb = BEVEL_LO_RGB;
        end else if (code == T_FLAG && centre) begin
            rgb = FLAG_RGB;
        end
    end

endmodule

// File: rtl/draw_board_tiles.sv
// VGA stage overlaying the Minesweeper tile grid, 3 register levels deep.
// Define DRAW_BOARD_CURSOR_EN to outline the tile under (cur_col, cur_row).
module draw_board_tiles
    import board_pkg::*;
#(
    parameter logic [10:0] BOARD_X   = 11'd192,
    parameter logic [10:0] BOARD_Y   = 11'd84,
    parameter int          TILE_LOG2 = 5,
    parameter int          COLS      = 16,
    parameter int          ROWS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    vga_if.in          in,
    vga_if.out         out,
    output logic [7:0] tile_addr,
    input  logic [3:0] tile_data,
    input  logic [3:0] cur_col,
    input  logic [3:0] cur_row
);

    localparam logic [10:0] BOARD_W = 11'(COLS << TILE_LOG2);
    localparam logic [10:0] BOARD_H = 11'(ROWS << TILE_LOG2);

    vga_t                 in_t;
    logic                 in_board_c;
    logic                 edge_c;
    logic                 hit_c;
    logic [10:0]          rel_x;
    logic [10:0]          rel_y;
    logic [3:0]           col_c;
    logic [3:0]           row_c;
    logic [TILE_LOG2-1:0] offx_c;
    logic [TILE_LOG2-1:0] offy_c;

    vga_t                 s1_t;
    logic                 s1_in_board;
    logic                 s1_edge;
    logic                 s1_hit;
    logic [TILE_LOG2-1:0] s1_offx;
    logic [TILE_LOG2-1:0] s1_offy;

    vga_t                 s2_t;
    logic                 s2_in_board;
    logic                 s2_edge;
    logic                 s2_hit;
    logic [TILE_LOG2-1:0] s2_offx;
    logic [TILE_LOG2-1:0] s2_offy;

    vga_t                 s3_t;
    logic [11:0]          paint_rgb;
    logic [11:0]          s3_rgb;

    assign in_t = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};

    assign in_board_c = !in.hblnk && !in.vblnk
                     && in.hcount >= BOARD_X && in.hcount < BOARD_X + BOARD_W
                     && in.vcount >= BOARD_Y && in.vcount < BOARD_Y + BOARD_H;

    // Offsets are forced to zero off-board so nothing downstream sees wrapped values.
    assign rel_x  = in_board_c ? in.hcount - BOARD_X : 11'd0;
    assign rel_y  = in_board_c ? in.vcount - BOARD_Y : 11'd0;
    assign col_c  = 4'(rel_x >> TILE_LOG2);
    assign row_c  = 4'(rel_y >> TILE_LOG2);
    assign offx_c = rel_x[TILE_LOG2-1:0];
    assign offy_c = rel_y[TILE_LOG2-1:0];
    assign edge_c = (rel_x == BOARD_W - 11'd1) || (rel_y == BOARD_H - 11'd1);

`ifdef DRAW_BOARD_CURSOR_EN
    // col_c/row_c never reach COLS/ROWS on-board, so an off-board cursor never matches.
    assign hit_c = in_board_c && (col_c == cur_col) && (row_c == cur_row);
`else
    logic unused_cursor;
    assign unused_cursor = ^{cur_col, cur_row};
    assign hit_c         = 1'b0;
`endif

    // S1: capture the pixel, its tile offsets and launch the tile-state read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_t        <= '0;
            s1_in_board <= 1'b0;
            s1_edge     <= 1'b0;
            s1_hit      <= 1'b0;
            s1_offx     <= '0;
            s1_offy     <= '0;
            tile_addr   <= 8'd0;
        end else begin
            s1_t        <= in_t;
            s1_in_board <= in_board_c;
            s1_edge     <= edge_c;
            s1_hit      <= hit_c;
            s1_offx     <= offx_c;
            s1_offy     <= offy_c;
            if (in_board_c) begin
                tile_addr <= 8'(row_c) * 8'(COLS) + 8'(col_c);
            end
        end
    end

    // S2: wait for the RAM, which registers tile_data on this same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_t        <= '0;
            s2_in_board <= 1'b0;
            s2_edge     <= 1'b0;
            s2_hit      <= 1'b0;
            s2_offx     <= '0;
            s2_offy     <= '0;
        end else begin
            s2_t        <= s1_t;
            s2_in_board <= s1_in_board;
            s2_edge     <= s1_edge;
            s2_hit      <= s1_hit;
            s2_offx     <= s1_offx;
            s2_offy     <= s1_offy;
        end
    end

    tile_painter #(
        .TILE_LOG2 (TILE_LOG2)
    ) painter (
        .code       (tile_data),
        .offx       (s2_offx),
        .offy       (s2_offy),
        .cursor_hit (s2_hit),
        .rgb        (paint_rgb)
    );

    assign s3_rgb = !s2_in_board ? s2_t.rgb : (s2_edge ? GRID_RGB : paint_rgb);

    // S3: final colour joins the delayed timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_t <= '0;
        end else begin
            s3_t     <= s2_t;
            s3_t.rgb <= s3_rgb;
        end
    end

    assign out.vcount = s3_t.vcount;
    assign out.vsync  = s3_t.vsync;
    assign out.vblnk  = s3_t.vblnk;
    assign out.hcount = s3_t.hcount;
    assign out.hsync  = s3_t.hsync;
    assign out.hblnk  = s3_t.hblnk;
    assign out.rgb    = s3_t.rgb;

endmodule

// File: tb/tb_draw_board_tiles.sv
// Randomized bench for draw_board_tiles against a pixel-level board model,
// plus hand-computed pixels; honours DRAW_BOARD_CURSOR_EN like the design.
`timescale 1ns/1ps
module tb_draw_board_tiles;

    localparam logic [10:0] BX   = 11'd192;
    localparam logic [10:0] BY   = 11'd84;
    localparam int          TILE = 32;
    localparam int          COLS = 16;
    localparam int          ROWS = 16;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        rst;
        logic [3:0]  cc;
        logic [3:0]  cr;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tile_addr;
    logic [3:0] tile_data;
    logic [3:0] cur_col;
    logic [3:0] cur_row;

    logic [3:0] mem [256];
    pix_t       hist [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_addr = 0;
    logic [3:0] cur_sel_c = 4'd15;
    logic [3:0] cur_sel_r = 4'd15;

    vga_if vin ();
    vga_if vout ();

    draw_board_tiles #(
        .BOARD_X   (BX),
        .BOARD_Y   (BY),
        .TILE_LOG2 (5),
        .COLS      (COLS),
        .ROWS      (ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (vin),
        .out       (vout),
        .tile_addr (tile_addr),
        .tile_data (tile_data),
        .cur_col   (cur_col),
        .cur_row   (cur_row)
    );

    always #5 clk = ~clk;

    // Synchronous tile-state RAM with one cycle of read latency.
    always @(posedge clk) tile_data <= mem[tile_addr];

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit in_board(input pix_t p);
        int rx = int'(p.hc) - int'(BX);
        int ry = int'(p.vc) - int'(BY);
        return !p.hb && !p.vb && rx >= 0 && rx < COLS * TILE && ry >= 0 && ry < ROWS * TILE;
    endfunction

    function automatic int addr_of(input pix_t p);
        return ((int'(p.vc) - int'(BY)) / TILE) * COLS + (int'(p.hc) - int'(BX)) / TILE;
    endfunction

    function automatic logic [11:0] count_colour(input int code);
        case (code)
            1:       return 12'h00F;
            2:       return 12'h080;
            3:       return 12'hF00;
            4:       return 12'h008;
            5:       return 12'h800;
            6:       return 12'h088;
            7:       return 12'h000;
            default: return 12'h888;
        endcase
    endfunction

    function automatic int dist_mid(input int o);
        return (o >= TILE / 2) ? o - TILE / 2 : TILE / 2 - o;
    endfunction

    function automatic logic [11:0] model_rgb(input pix_t p);
        int rx, ry, ox, oy, code;
        bit centre, band_hi, band_lo;
        if (!in_board(p)) return p.rgb;
        rx   = int'(p.hc) - int'(BX);
        ry   = int'(p.vc) - int'(BY);
        ox   = rx % TILE;
        oy   = ry % TILE;
        code = int'(mem[addr_of(p)]);
        if (ox == 0 || oy == 0 || rx == COLS * TILE - 1 || ry == ROWS * TILE - 1) return 12'h444;
        centre  = dist_mid(ox) < TILE / 4 && dist_mid(oy) < TILE / 4;
        band_hi = (ox inside {[1:2]}) || (oy inside {[1:2]});
        band_lo = ox >= TILE - 2 || oy >= TILE - 2;
`ifdef DRAW_BOARD_CURSOR_EN
        if (rx / TILE == int'(p.cc) && ry / TILE == int'(p.cr) && (band_hi || band_lo)) return 12'hFF0;
`endif
        if (code <= 8) return (code >= 1 && centre) ? count_colour(code) : 12'hCCC;
        if (code == 11) return centre ? 12'h000 : 12'hF00;
        if (band_hi) return 12'hEEE;
        if (band_lo) return 12'h666;
        if (code == 10 && centre) return 12'hF00;
        return 12'hAAA;
    endfunction

    function automatic pix_t mk(input int x, input int y, input logic [11:0] c, input logic vb);
        pix_t p = '0;
        p.hc  = 11'(x);
        p.vc  = 11'(y);
        p.rgb = c;
        p.vb  = vb;
        p.cc  = cur_sel_c;
        p.cr  = cur_sel_r;
        return p;
    endfunction

    task automatic drive(input pix_t p);
        vin.hcount = p.hc;
        vin.vcount = p.vc;
        vin.hsync  = p.hs;
        vin.vsync  = p.vs;
        vin.hblnk  = p.hb;
        vin.vblnk  = p.vb;
        vin.rgb    = p.rgb;
        rst        = p.rst;
        cur_col    = p.cc;
        cur_row    = p.cr;
        hist.push_back(p);
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    task automatic apply_stimulus(input pix_t p);
        @(posedge clk);
        #1;
        drive(p);
    endtask

    task automatic idle(input int n);
        pix_t p = mk(0, 0, 12'h000, 1'b1);
        p.hb = 1'b1;
        repeat (n) apply_stimulus(p);
    endtask

    function automatic pix_t rand_pixel();
        pix_t p;
        if ($urandom_range(0, 3) == 0)
            p = mk(int'(BX) + int'(cur_sel_c) * TILE + int'($urandom_range(0, TILE - 1)),
                   int'(BY) + int'(cur_sel_r) * TILE + int'($urandom_range(0, TILE - 1)),
                   12'($urandom()), 1'b0);
        else
            p = mk(int'(BX) - 20 + int'($urandom_range(0, 552)),
                   int'(BY) - 20 + int'($urandom_range(0, 552)),
                   12'($urandom()), 1'b0);
        p.hb  = ($urandom_range(0, 15) == 0);
        p.vb  = ($urandom_range(0, 15) == 0);
        p.hs  = 1'($urandom());
        p.vs  = 1'($urandom());
        p.rst = ($urandom_range(0, 99) == 0);
        return p;
    endfunction

    // Holds one pixel long enough to fill the pipeline, then checks literals.
    task automatic pin_pixel(input string name, input int x, input int y, input logic [3:0] code,
                             input logic vb, input logic [11:0] in_rgb, input logic [11:0] exp_rgb,
                             input int exp_a);
        pix_t p;
        idle(4);
        p = mk(x, y, in_rgb, vb);
        if (in_board(p)) mem[addr_of(p)] = code;
        repeat (4) apply_stimulus(p);
        @(negedge clk);
        check_output({name, "_rgb"}, 64'(vout.rgb), 64'(exp_rgb));
        if (exp_a >= 0) check_output({name, "_addr"}, 64'(tile_addr), 64'(exp_a));
    endtask

    // Model compare: every cycle, tile_addr and the 3-deep delayed output.
    initial begin
        int          n;
        pix_t        p;
        bit          flushed;
        logic [36:0] exp_t;
        logic [36:0] got_t;
        forever begin
            @(negedge clk);
            n = hist.size();
            if (n >= 2) begin
                p = hist[n-2];
                if (p.rst) exp_addr = 0;
                else if (in_board(p)) exp_addr = addr_of(p);
                check_output("model_tile_addr", 64'(tile_addr), 64'(exp_addr));
            end
            if (n >= 4) begin
                p       = hist[n-4];
                flushed = hist[n-4].rst || hist[n-3].rst || hist[n-2].rst;
                got_t   = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
                exp_t   = flushed ? 37'd0 : {p.vc, p.vs, p.vb, p.hc, p.hs, p.hb, model_rgb(p)};
                check_output("model_out", 64'(got_t), 64'(exp_t));
            end
        end
    end

    initial begin
        pix_t p;
        for (int i = 0; i < 256; i++) mem[i] = 4'd9;

        p     = mk(int'(BX) + 40, int'(BY) + 70, 12'h123, 1'b0);
        p.rst = 1'b1;
        drive(p);
        repeat (5) begin
            p     = rand_pixel();
            p.hb  = 1'b0;
            p.vb  = 1'b0;
            p.rst = 1'b1;
            apply_stimulus(p);
        end
        @(negedge clk);
        check_output("reset_out", 64'({vout.vcount, vout.vsync, vout.vblnk, vout.hcount,
                                       vout.hsync, vout.hblnk, vout.rgb}), 64'd0);
        check_output("reset_addr", 64'(tile_addr), 64'd0);

        for (int h = 300; h < 310; h++) apply_stimulus(mk(h, 10, 12'h555, 1'b0));
        @(negedge clk);
        check_output("align_hcount", 64'(vout.hcount), 64'd306);

        pin_pixel("hidden",    int'(BX) + 40,  int'(BY) + 70, 4'd9,  1'b0, 12'h123, 12'hAAA, 33);
        pin_pixel("count3",    int'(BX) + 48,  int'(BY) + 80, 4'd3,  1'b0, 12'h123, 12'hF00, 33);
        pin_pixel("mine",      int'(BX) + 48,  int'(BY) + 80, 4'd11, 1'b0, 12'h123, 12'h000, 33);
        pin_pixel("mine_bg",   int'(BX) + 40,  int'(BY) + 70, 4'd11, 1'b0, 12'h123, 12'hF00, 33);
        pin_pixel("flag",      int'(BX) + 48,  int'(BY) + 80, 4'd10, 1'b0, 12'h123, 12'hF00, 33);
        pin_pixel("flag_bev",  int'(BX) + 33,  int'(BY) + 80, 4'd10, 1'b0, 12'h123, 12'hEEE, 33);
        pin_pixel("rev0",      int'(BX) + 48,  int'(BY) + 80, 4'd0,  1'b0, 12'h123, 12'hCCC, 33);
        pin_pixel("code14",    int'(BX) + 40,  int'(BY) + 70, 4'd14, 1'b0, 12'h123, 12'hAAA, 33);
        pin_pixel("left_out",  int'(BX) - 1,   int'(BY) + 70, 4'd9,  1'b0, 12'h888, 12'h888, 33);
        pin_pixel("right_out", int'(BX) + 512, int'(BY) + 70, 4'd9,  1'b0, 12'h888, 12'h888, 33);
        pin_pixel("first_col", int'(BX),       int'(BY) + 70, 4'd9,  1'b0, 12'h888, 12'h444, 32);
        pin_pixel("last_col",  int'(BX) + 511, int'(BY) + 70, 4'd9,  1'b0, 12'h888, 12'h444, 47);
        pin_pixel("bevel_lo",  int'(BX) + 62,  int'(BY) + 70, 4'd9,  1'b0, 12'h123, 12'h666, 33);
        pin_pixel("vblank",    int'(BX) + 100, int'(BY) + 100, 4'd9, 1'b1, 12'h000, 12'h000, 33);

        cur_sel_c = 4'd1;
        cur_sel_r = 4'd2;
`ifdef DRAW_BOARD_CURSOR_EN
        pin_pixel("cursor_hid", int'(BX) + 33, int'(BY) + 74, 4'd9, 1'b0, 12'h123, 12'hFF0, 33);
        pin_pixel("cursor_rev", int'(BX) + 63, int'(BY) + 74, 4'd5, 1'b0, 12'h123, 12'hFF0, 33);
`else
        pin_pixel("cursor_hid", int'(BX) + 33, int'(BY) + 74, 4'd9, 1'b0, 12'h123, 12'hEEE, 33);
        pin_pixel("cursor_rev", int'(BX) + 63, int'(BY) + 74, 4'd5, 1'b0, 12'h123, 12'hCCC, 33);
`endif
        pin_pixel("cursor_grid", int'(BX) + 32, int'(BY) + 74, 4'd9, 1'b0, 12'h123, 12'h444, 33);

        idle(4);
        for (int i = 0; i < 256; i++) mem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                cur_sel_c = 4'($urandom());
                cur_sel_r = 4'($urandom());
            end
            apply_stimulus(rand_pixel());
        end
        idle(4);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
